// File: rtl/maxpool_pkg.sv
// Shared definitions for the 2x2 stride-2 max-pooling stream stage.
package maxpool_pkg;

    typedef enum logic [1:0] {
        MP_IDLE  = 2'd0,
        MP_RUN   = 2'd1,
        MP_DRAIN = 2'd2
    } mp_state_e;

    // Comparator width; pixels are zero-extended so the compare stays unsigned.
    localparam int MP_MAX_W = 32;

    function automatic logic [MP_MAX_W-1:0] mp_max(input logic [MP_MAX_W-1:0] a,
                                                   input logic [MP_MAX_W-1:0] b);
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_line_buf.sv
// Partial-max line buffer: one entry per pooling window column, one write port, async read.
module maxpool_line_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 3,
    parameter int AW     = 2
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // No reset: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over an HxW unsigned frame, valid/ready in and out.
//   state    | meaning
//   MP_IDLE  | waiting for start, input blocked
//   MP_RUN   | accepting pixels of the frame
//   MP_DRAIN | last pixel taken, waiting for the final result to leave
module maxpool_2x2_stream
    import maxpool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int H      = 6,
    parameter int W      = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int RW       = (H > 1) ? $clog2(H) : 1;
    localparam int CW       = (W > 1) ? $clog2(W) : 1;
    localparam int LB_DEPTH = (W / 2 > 0) ? W / 2 : 1;
    localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    mp_state_e         state_q;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;

    logic              acc, out_xfer, emit, lbuf_we, last_col, last_row;
    logic [AW-1:0]     lbuf_idx;
    logic [DATA_W-1:0] lbuf_rdata, pair_max_d, win_max_d;

    assign in_ready = (state_q == MP_RUN) && (!out_valid_q || out_ready);
    assign acc      = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;
    assign last_col = (col_q == CW'(W - 1));
    assign last_row = (row_q == RW'(H - 1));
    assign lbuf_we  = acc && col_q[0] && !row_q[0];
    assign emit     = acc && col_q[0] && row_q[0];
    assign lbuf_idx = AW'(col_q >> 1);

    assign pair_max_d = DATA_W'(mp_max(MP_MAX_W'(hold_q), MP_MAX_W'(in_data)));
    assign win_max_d  = DATA_W'(mp_max(MP_MAX_W'(lbuf_rdata), MP_MAX_W'(pair_max_d)));

    assign busy      = (state_q != MP_IDLE);
    assign done      = (state_q == MP_DRAIN) && (!out_valid_q || out_ready);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    maxpool_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (LB_DEPTH),
        .AW     (AW)
    ) u_lbuf (
        .clk_i   (clk),
        .we_i    (lbuf_we),
        .waddr_i (lbuf_idx),
        .wdata_i (pair_max_d),
        .raddr_i (lbuf_idx),
        .rdata_o (lbuf_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= MP_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (acc && !col_q[0]) hold_q <= in_data;

            // A new result wins over retiring the old one in the same cycle.
            if (emit) begin
                out_data_q  <= win_max_d;
                out_valid_q <= 1'b1;
            end else if (out_xfer) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                MP_IDLE: begin
                    if (start) begin
                        row_q   <= '0;
                        col_q   <= '0;
                        state_q <= MP_RUN;
                    end
                end
                MP_RUN: begin
                    if (acc) begin
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                row_q   <= '0;
                                state_q <= MP_DRAIN;
                            end else begin
                                row_q <= row_q + RW'(1);
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                MP_DRAIN: begin
                    if (done) state_q <= MP_IDLE;
                end
                default: state_q <= MP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Directed bench: three pool instances (4x4, 6x6, 5x5) driven with hand-computed vectors.
module tb_maxpool_2x2_stream;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start     [3];
    logic [7:0] in_data   [3];
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic [7:0] out_data  [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic       busy      [3];
    logic       done      [3];

    int n_chk = 0;
    int n_bad = 0;
    int pix [64];
    int exp_q [16];
    int cap [3][32];
    int cap_n [3] = '{0, 0, 0};
    int done_cnt [3] = '{0, 0, 0};
    int busy_cnt [3] = '{0, 0, 0};
    int last_guard;
    int base_o, base_d, base_b;

    always #5 clk = ~clk;

    maxpool_2x2_stream #(.DATA_W(8), .H(4), .W(4)) u0 (
        .clk(clk), .rstn(rstn), .start(start[0]), .in_data(in_data[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .out_data(out_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .busy(busy[0]), .done(done[0]));

    maxpool_2x2_stream #(.DATA_W(8), .H(6), .W(6)) u1 (
        .clk(clk), .rstn(rstn), .start(start[1]), .in_data(in_data[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .out_data(out_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .busy(busy[1]), .done(done[1]));

    maxpool_2x2_stream #(.DATA_W(8), .H(5), .W(5)) u2 (
        .clk(clk), .rstn(rstn), .start(start[2]), .in_data(in_data[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .out_data(out_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .busy(busy[2]), .done(done[2]));

    // Inputs change just after posedge, so negedge values predict the next edge's transfers.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (out_valid[k] && out_ready[k]) begin
                if (cap_n[k] < 32) cap[k][cap_n[k]] = int'(out_data[k]);
                cap_n[k] = cap_n[k] + 1;
            end
            if (done[k]) done_cnt[k] = done_cnt[k] + 1;
            if (busy[k]) busy_cnt[k] = busy_cnt[k] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic feed(input int k, input int n);
        int  i;
        int  guard;
        logic acc;
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        i = 0;
        guard = 0;
        in_valid[k] = 1'b1;
        in_data[k]  = 8'(pix[0]);
        while (i < n && guard < 400) begin
            @(negedge clk);
            acc = in_ready[k];
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                i++;
                if (i < n) in_data[k] = 8'(pix[i]);
            end
        end
        in_valid[k] = 1'b0;
        last_guard = guard;
        chk("feed_accepted", i, n);
    endtask

    task automatic snap(input int k);
        base_o = cap_n[k];
        base_d = done_cnt[k];
        base_b = busy_cnt[k];
    endtask

    task automatic check_outs(input int k, input int n);
        chk("n_out", cap_n[k] - base_o, n);
        for (int j = 0; j < n; j++)
            if (base_o + j < 32)
                chk($sformatf("u%0d_out%0d", k, j), cap[k][base_o + j], exp_q[j]);
        chk("done_pulses", done_cnt[k] - base_d, 1);
    endtask

    initial begin
        rstn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0; in_data[k] = 8'h00; in_valid[k] = 1'b0; out_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", out_valid[k], 0);
            chk("rst_out_data", out_data[k], 0);
            chk("rst_busy", busy[k], 0);
            chk("rst_in_ready", in_ready[k], 0);
            chk("rst_done", done[k], 0);
        end
        rstn = 1'b1;
        @(posedge clk); #1;

        // 4x4 ascending, free-flowing output
        for (int i = 0; i < 16; i++) pix[i] = i + 1;
        exp_q[0] = 6; exp_q[1] = 8; exp_q[2] = 14; exp_q[3] = 16;
        snap(0);
        feed(0, 16);
        @(negedge clk);
        chk("done_after_last", done[0], 1);
        @(negedge clk);
        chk("done_one_cycle", done[0], 0);
        chk("idle_busy", busy[0], 0);
        chk("idle_in_ready", in_ready[0], 0);
        repeat (3) @(posedge clk); #1;
        check_outs(0, 4);

        // 6x6 descending: every window max is its top-left pixel
        for (int i = 0; i < 36; i++) pix[i] = 36 - i;
        exp_q[0] = 36; exp_q[1] = 34; exp_q[2] = 32; exp_q[3] = 24; exp_q[4] = 22;
        exp_q[5] = 20; exp_q[6] = 12; exp_q[7] = 10; exp_q[8] = 8;
        snap(1);
        feed(1, 36);
        chk("no_in_ready_gaps", last_guard, 36);
        repeat (5) @(posedge clk); #1;
        chk("busy_cycles", busy_cnt[1] - base_b, 37);
        check_outs(1, 9);

        // 4x4 with output stalled after the first result
        for (int i = 0; i < 16; i++) pix[i] = i + 1;
        exp_q[0] = 6; exp_q[1] = 8; exp_q[2] = 14; exp_q[3] = 16;
        snap(0);
        out_ready[0] = 1'b0;
        fork
            feed(0, 16);
            begin : stall_ctl
                int g;
                g = 0;
                while (!out_valid[0] && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                chk("bp_first_valid", out_valid[0], 1);
                repeat (4) @(negedge clk);
                chk("bp_in_ready_low", in_ready[0], 0);
                chk("bp_data_held", out_data[0], 6);
                chk("bp_valid_held", out_valid[0], 1);
                @(posedge clk); #1;
                out_ready[0] = 1'b1;
            end
        join
        repeat (5) @(posedge clk); #1;
        check_outs(0, 4);

        // 5x5: last row and column dropped
        for (int i = 0; i < 25; i++) pix[i] = i + 1;
        exp_q[0] = 7; exp_q[1] = 9; exp_q[2] = 17; exp_q[3] = 19;
        snap(2);
        feed(2, 25);
        repeat (5) @(posedge clk); #1;
        check_outs(2, 4);

        // unsigned compare and ties
        pix[0]  = 8'h7F; pix[1]  = 8'h80; pix[2]  = 8'h80; pix[3]  = 8'h7F;
        pix[4]  = 8'h00; pix[5]  = 8'hFF; pix[6]  = 8'h7F; pix[7]  = 8'h7F;
        pix[8]  = 8'h10; pix[9]  = 8'h10; pix[10] = 8'h00; pix[11] = 8'h01;
        pix[12] = 8'h10; pix[13] = 8'h10; pix[14] = 8'hFE; pix[15] = 8'h02;
        exp_q[0] = 8'hFF; exp_q[1] = 8'h80; exp_q[2] = 8'h10; exp_q[3] = 8'hFE;
        snap(0);
        feed(0, 16);
        repeat (5) @(posedge clk); #1;
        check_outs(0, 4);

        // reset in the middle of a 6x6 frame, then a clean frame
        for (int i = 0; i < 36; i++) pix[i] = i + 1;
        out_ready[1] = 1'b0;
        feed(1, 8);
        @(negedge clk);
        chk("mid_valid_before_rst", out_valid[1], 1);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid[1], 0);
        chk("mid_rst_out_data", out_data[1], 0);
        chk("mid_rst_busy", busy[1], 0);
        chk("mid_rst_in_ready", in_ready[1], 0);
        rstn = 1'b1;
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        exp_q[0] = 8;  exp_q[1] = 10; exp_q[2] = 12; exp_q[3] = 20; exp_q[4] = 22;
        exp_q[5] = 24; exp_q[6] = 32; exp_q[7] = 34; exp_q[8] = 36;
        snap(1);
        feed(1, 36);
        repeat (5) @(posedge clk); #1;
        check_outs(1, 9);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
